// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_pkg;
   typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;
   localparam int         REG_ADDR_W = 5;
   localparam logic [4:0] ZERO_REG   = 5'd0;
   localparam int         MD_CNT_W   = 4;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; perf counters exist only with PIPE_HAZARD_PERF_EN.
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
`ifdef PIPE_HAZARD_PERF_EN
   , parameter int PERF_W = 16
`endif
);
   logic [REG_ADDR_W-1:0] id_rs_addr;
   logic [REG_ADDR_W-1:0] id_rt_addr;
   logic                  id_uses_rs;
   logic                  id_uses_rt;
   logic                  id_is_md;
   logic                  id_reads_hilo;
   logic                  exe_mem_read;
   logic [REG_ADDR_W-1:0] exe_rd_addr;
   logic                  exe_redirect;
   logic                  pc_write;
   logic                  if_id_write;
   logic                  if_id_flush;
   logic                  id_exe_bubble;
   logic                  md_start;
   logic                  md_busy;
   logic                  md_done;
`ifdef PIPE_HAZARD_PERF_EN
   logic [PERF_W-1:0]     perf_stall_cycles;
   logic [PERF_W-1:0]     perf_flushes;
`endif

   modport master (
      output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo,
             exe_mem_read, exe_rd_addr, exe_redirect,
`ifdef PIPE_HAZARD_PERF_EN
      input  perf_stall_cycles, perf_flushes,
`endif
      input  pc_write, if_id_write, if_id_flush, id_exe_bubble, md_start, md_busy, md_done
   );

   modport slave (
      input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo,
             exe_mem_read, exe_rd_addr, exe_redirect,
`ifdef PIPE_HAZARD_PERF_EN
      output perf_stall_cycles, perf_flushes,
`endif
      output pc_write, if_id_write, if_id_flush, id_exe_bubble, md_start, md_busy, md_done
   );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// HI/LO unit occupancy timer: busy for LATENCY cycles after start, done in the last one.
module md_busy_timer #(
   parameter int LATENCY = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done
);
   import pipe_hazard_pkg::*;

   localparam logic [MD_CNT_W-1:0] LOAD = MD_CNT_W'(LATENCY - 1);

   md_state_t            state, state_nx;
   logic [MD_CNT_W-1:0]  count, count_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MD_IDLE;
         count <= '0;
      end else begin
         state <= state_nx;
         count <= count_nx;
      end
   end

   always_comb begin
      state_nx = state;
      count_nx = count;
      case (state)
         MD_IDLE: begin
            if (start) begin
               state_nx = MD_BUSY;
               count_nx = LOAD;
            end
         end
         MD_BUSY: begin
            if (count == '0) state_nx = MD_IDLE;
            else             count_nx = count - 1'b1;
         end
         default: state_nx = MD_IDLE;
      endcase
   end

   assign busy = (state == MD_BUSY);
   assign done = (state == MD_BUSY) && (count == '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline; PIPE_HAZARD_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int MD_LATENCY = 4
`ifdef PIPE_HAZARD_PERF_EN
   , parameter int PERF_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   import pipe_hazard_pkg::*;

   logic rs_hit, rt_hit, load_use, hilo_wait;
   logic md_start, md_busy, md_done;
   logic pc_write, if_id_write, if_id_flush, id_exe_bubble;

   always_comb begin
      rs_hit    = bus.id_uses_rs && (bus.id_rs_addr == bus.exe_rd_addr);
      rt_hit    = bus.id_uses_rt && (bus.id_rt_addr == bus.exe_rd_addr);
      load_use  = bus.exe_mem_read && (bus.exe_rd_addr != REG_ADDR_W'(ZERO_REG)) && (rs_hit || rt_hit);
      hilo_wait = (bus.id_is_md || bus.id_reads_hilo) && md_busy;
      md_start  = !rst && bus.id_is_md && !md_busy && !bus.exe_redirect && !load_use;
   end

   // Redirect beats stalls: whatever sits in ID is wrong-path anyway.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_exe_bubble = 1'b0;
      if (rst) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_exe_bubble = 1'b1;
      end else if (bus.exe_redirect) begin
         if_id_flush   = 1'b1;
         id_exe_bubble = 1'b1;
      end else if (load_use || hilo_wait) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_exe_bubble = 1'b1;
      end
   end

   md_busy_timer #(.LATENCY(MD_LATENCY)) u_md_timer (
      .clk  (clk),
      .rst  (rst),
      .start(md_start),
      .busy (md_busy),
      .done (md_done)
   );

   assign bus.pc_write      = pc_write;
   assign bus.if_id_write   = if_id_write;
   assign bus.if_id_flush   = if_id_flush;
   assign bus.id_exe_bubble = id_exe_bubble;
   assign bus.md_start      = md_start;
   assign bus.md_busy       = md_busy;
   assign bus.md_done       = md_done;

`ifdef PIPE_HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cnt, flush_cnt;

   // Saturating counters; reset cycles are never counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && stall_cnt != '1)        stall_cnt <= stall_cnt + 1'b1;
         if (bus.exe_redirect && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.perf_stall_cycles = stall_cnt;
   assign bus.perf_flushes      = flush_cnt;
`endif
endmodule
